// File: rtl/tank_expl_pkg.sv
// Shared types, widths and helpers for the tank explosion sprite.
// Optional macro TANK_EXPL_TRANSPARENT_EN is consumed by tank_explosion_sprite.
package tank_expl_pkg;

  localparam int COORD_W = 10;
  localparam int IDX_W   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  function automatic int rom_addr_w(input int num_frames, input int sprite_w, input int sprite_h);
    return $clog2(num_frames * sprite_w * sprite_h);
  endfunction

  // Procedural burst art: colour bands sweep diagonally and shift by 3 each frame.
  function automatic logic [IDX_W-1:0] burst_pixel(input int frame, input int y, input int x);
    return IDX_W'(x + y + 3 * frame);
  endfunction

endpackage

// File: rtl/tank_expl_rom.sv
// Synchronous-read explosion frame ROM, frame 0 first, 4-bit palette indices.
module tank_expl_rom
  import tank_expl_pkg::*;
#(
  parameter int SPRITE_W   = 32,
  parameter int SPRITE_H   = 32,
  parameter int NUM_FRAMES = 6,
  parameter int ADDR_W     = rom_addr_w(NUM_FRAMES, SPRITE_W, SPRITE_H)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  data
);

  localparam int DEPTH = NUM_FRAMES * SPRITE_W * SPRITE_H;
  localparam int XW    = $clog2(SPRITE_W);
  localparam int YW    = $clog2(SPRITE_H);

  int a_int;
  assign a_int = int'(addr);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data <= '0;
    end else if (a_int < DEPTH) begin
      data <= burst_pixel(a_int >> (XW + YW), (a_int >> XW) % SPRITE_H, a_int % SPRITE_W);
    end else begin
      data <= '0;
    end
  end

endmodule

// File: rtl/tank_explosion_sprite.sv
// Explosion animation sequencer plus 2-cycle pixel pipeline feeding the palette stage.
// Define TANK_EXPL_TRANSPARENT_EN to treat ROM index 0 as transparent.
module tank_explosion_sprite
  import tank_expl_pkg::*;
#(
  parameter int SPRITE_W   = 32,
  parameter int SPRITE_H   = 32,
  parameter int NUM_FRAMES = 6,
  parameter int FRAME_HOLD = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               vsync_tick,
  input  logic               trigger,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   pix_idx,
  output logic               pix_on
);

  localparam int ADDR_W  = rom_addr_w(NUM_FRAMES, SPRITE_W, SPRITE_H);
  localparam int XW      = $clog2(SPRITE_W);
  localparam int YW      = $clog2(SPRITE_H);
  localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int HOLD_W  = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [COORD_W:0] W_EXT = (COORD_W + 1)'(SPRITE_W);
  localparam logic [COORD_W:0] H_EXT = (COORD_W + 1)'(SPRITE_H);

  state_e              state, state_n;
  logic [FRAME_W-1:0]  frame, frame_n;
  logic [HOLD_W-1:0]   hold, hold_n;
  logic [COORD_W-1:0]  org_x, org_x_n, org_y, org_y_n;
  logic                done_n;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      frame <= '0;
      hold  <= '0;
      org_x <= '0;
      org_y <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      frame <= frame_n;
      hold  <= hold_n;
      org_x <= org_x_n;
      org_y <= org_y_n;
      done  <= done_n;
    end
  end

  // A trigger always takes priority; a coincident vsync tick is dropped.
  always_comb begin
    state_n = state;
    frame_n = frame;
    hold_n  = hold;
    org_x_n = org_x;
    org_y_n = org_y;
    done_n  = 1'b0;
    if (trigger) begin
      state_n = PLAY;
      frame_n = '0;
      hold_n  = '0;
      org_x_n = pos_x;
      org_y_n = pos_y;
    end else if (state == PLAY && vsync_tick) begin
      if (hold == HOLD_W'(FRAME_HOLD - 1)) begin
        hold_n = '0;
        if (frame == FRAME_W'(NUM_FRAMES - 1)) begin
          state_n = IDLE;
          frame_n = '0;
          done_n  = 1'b1;
        end else begin
          frame_n = frame + 1'b1;
        end
      end else begin
        hold_n = hold + 1'b1;
      end
    end
  end

  assign busy = (state == PLAY);

  // Stage 1: box test in 11 bits so a sprite near the right/bottom edge never wraps.
  logic [COORD_W:0] ex, ey, ox, oy;
  logic             in_box;
  logic [XW-1:0]    dx;
  logic [YW-1:0]    dy;
  logic [ADDR_W-1:0] addr_n, addr_q;
  logic             in_box_q, vis_q;
  logic [IDX_W-1:0] rom_data;

  assign ex = {1'b0, draw_x};
  assign ey = {1'b0, draw_y};
  assign ox = {1'b0, org_x};
  assign oy = {1'b0, org_y};
  assign in_box = busy && (ex >= ox) && (ex < ox + W_EXT) && (ey >= oy) && (ey < oy + H_EXT);
  assign dx = draw_x[XW-1:0] - org_x[XW-1:0];
  assign dy = draw_y[YW-1:0] - org_y[YW-1:0];
  assign addr_n = (ADDR_W'(frame) << (XW + YW)) | (ADDR_W'(dy) << XW) | ADDR_W'(dx);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_box_q <= 1'b0;
      addr_q   <= '0;
      vis_q    <= 1'b0;
    end else begin
      in_box_q <= in_box;
      addr_q   <= addr_n;
      vis_q    <= in_box_q;
    end
  end

  tank_expl_rom #(
    .SPRITE_W  (SPRITE_W),
    .SPRITE_H  (SPRITE_H),
    .NUM_FRAMES(NUM_FRAMES),
    .ADDR_W    (ADDR_W)
  ) u_rom (
    .clk    (clk),
    .reset_n(reset_n),
    .addr   (addr_q),
    .data   (rom_data)
  );

  // Stage 2: registered ROM data and delayed box flag.
  assign pix_idx = vis_q ? rom_data : '0;
`ifdef TANK_EXPL_TRANSPARENT_EN
  assign pix_on = vis_q && (rom_data != '0);
`else
  assign pix_on = vis_q;
`endif

endmodule
